// File: rtl/ucomb_cfg_seq.sv
// Serial config loader and settle/capture sequencer wrapped around one ucomb_full.
// Define UCOMB_CFG_PARITY_EN to require a trailing even-parity bit on the stream.
module ucomb_cfg_seq #(
    parameter int CFG_W  = 23,
    parameter int DIN_W  = 4,
    parameter int DOUT_W = 6,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_en,
    input  logic                   cfg_bit,
    input  logic                   cfg_commit,
    output logic                   cfg_err,
    output logic                   cfg_valid,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [DIN_W-1:0]       op_data,
    output logic [CFG_W+DIN_W-1:0] comb_in,
    input  logic [DOUT_W-1:0]      comb_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DOUT_W-1:0]      res_data,
    output logic                   busy
);

`ifdef UCOMB_CFG_PARITY_EN
    localparam int SH_W = CFG_W + 1;
`else
    localparam int SH_W = CFG_W;
`endif
    localparam int CNT_W = $clog2(SH_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]        state;
    logic [SH_W-1:0]   shadow;
    logic [SH_W-1:0]   shadow_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CFG_W-1:0]  cfg_active;
    logic [CFG_W-1:0]  new_word;
    logic [DIN_W-1:0]  op_hold;
    logic [3:0]        settle_cnt;
    logic              idle;
    logic              shift_ok;
    logic              commit_try;
    logic              word_ok;
    logic              op_fire;

    assign idle       = (state == S_IDLE);
    assign shift_ok   = cfg_en & idle;
    assign commit_try = cfg_commit & idle;
    assign op_ready   = idle & cfg_valid & ~cfg_commit;
    assign op_fire    = op_valid & op_ready;
    assign busy       = ~idle;
    assign comb_in    = {cfg_active, op_hold};

    // The commit sees the shadow and count after any same-cycle shift.
    always_comb begin
        shadow_nxt = shadow;
        cnt_nxt    = bit_cnt;
        if (shift_ok) begin
            shadow_nxt = {shadow[SH_W-2:0], cfg_bit};
            if (bit_cnt != CNT_W'(SH_W))
                cnt_nxt = bit_cnt + CNT_W'(1);
        end
    end

`ifdef UCOMB_CFG_PARITY_EN
    assign word_ok  = (cnt_nxt == CNT_W'(SH_W)) & ~(^shadow_nxt);
    assign new_word = shadow_nxt[SH_W-1:1];
`else
    assign word_ok  = (cnt_nxt == CNT_W'(SH_W));
    assign new_word = shadow_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow     <= '0;
            bit_cnt    <= '0;
            cfg_active <= '0;
            cfg_valid  <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            if (commit_try) begin
                bit_cnt <= '0;
                if (word_ok) begin
                    cfg_active <= new_word;
                    cfg_valid  <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else begin
                bit_cnt <= cnt_nxt;
            end
            // Config traffic while evaluating would disturb comb_in.
            if (~idle && (cfg_en || cfg_commit))
                cfg_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_hold    <= '0;
            settle_cnt <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (op_fire) begin
                        op_hold    <= op_data;
                        settle_cnt <= 4'(SETTLE - 1);
                        state      <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (settle_cnt == 4'd0) begin
                        res_data  <= comb_out;
                        res_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ucomb_cfg_seq.sv
// Directed bench for ucomb_cfg_seq; comb_out comes from a small stand-in
// function of comb_in (plus a perturbation term) instead of a real ucomb_full.
module tb_ucomb_cfg_seq;

    localparam int CFG_W  = 23;
    localparam int DIN_W  = 4;
    localparam int DOUT_W = 6;
    localparam int SETTLE = 2;
`ifdef UCOMB_CFG_PARITY_EN
    localparam int SH_W = CFG_W + 1;
`else
    localparam int SH_W = CFG_W;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cfg_en;
    logic                   cfg_bit;
    logic                   cfg_commit;
    logic                   cfg_err;
    logic                   cfg_valid;
    logic                   op_valid;
    logic                   op_ready;
    logic [DIN_W-1:0]       op_data;
    logic [CFG_W+DIN_W-1:0] comb_in;
    logic [DOUT_W-1:0]      comb_out;
    logic                   res_valid;
    logic                   res_ready;
    logic [DOUT_W-1:0]      res_data;
    logic                   busy;
    logic [DOUT_W-1:0]      pert;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [CFG_W-1:0] W1 = 23'b10011000000000000000100;
    localparam logic [CFG_W-1:0] W2 = 23'h2A5A5A;

    ucomb_cfg_seq #(
        .CFG_W (CFG_W),
        .DIN_W (DIN_W),
        .DOUT_W(DOUT_W),
        .SETTLE(SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_en    (cfg_en),
        .cfg_bit   (cfg_bit),
        .cfg_commit(cfg_commit),
        .cfg_err   (cfg_err),
        .cfg_valid (cfg_valid),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_data   (op_data),
        .comb_in   (comb_in),
        .comb_out  (comb_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign comb_out = comb_in[5:0] ^ comb_in[26:21] ^ pert;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends the leading nbits of the stream, optionally after some junk bits.
    task automatic shift_word(input logic [CFG_W-1:0] w, input int lead,
                              input int nbits, input bit commit_last,
                              input bit flip_par);
        logic [SH_W-1:0] s;
`ifdef UCOMB_CFG_PARITY_EN
        s = {w, (^w) ^ flip_par};
`else
        s = w;
        if (flip_par) s = ~w;
`endif
        for (int i = 0; i < lead; i++) begin
            cfg_en = 1'b1;
            cfg_bit = 1'b1;
            tick();
        end
        for (int i = SH_W - 1; i >= SH_W - nbits; i--) begin
            cfg_en = 1'b1;
            cfg_bit = s[i];
            cfg_commit = commit_last && (i == SH_W - nbits);
            tick();
        end
        cfg_en = 1'b0;
        cfg_bit = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cfg_en = 1'b0;
        cfg_bit = 1'b0;
        cfg_commit = 1'b0;
        op_valid = 1'b0;
        op_data = '0;
        res_ready = 1'b0;
        pert = '0;
        tick();
        tick();
        chk("rst_cfg_valid", 32'(cfg_valid), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_op_ready", 32'(op_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_comb_in", 32'(comb_in), 32'd0);
        rst = 1'b0;
        tick();

        shift_word(W1, 0, SH_W, 1'b0, 1'b0);
        commit();
        chk("cfg1_valid", 32'(cfg_valid), 32'd1);
        chk("cfg1_err", 32'(cfg_err), 32'd0);
        chk("cfg1_comb_in", 32'(comb_in), 32'({W1, 4'b0000}));

        cfg_commit = 1'b1;
        #1;
        chk("ready_blk_commit", 32'(op_ready), 32'd0);
        cfg_commit = 1'b0;
        #1;

        op_data = 4'b0011;
        op_valid = 1'b1;
        #1;
        chk("op1_ready", 32'(op_ready), 32'd1);
        tick();
        op_valid = 1'b0;
        chk("op1_busy", 32'(busy), 32'd1);
        chk("op1_ready_low", 32'(op_ready), 32'd0);
        chk("op1_comb_in", 32'(comb_in), 32'({W1, 4'b0011}));
        tick();
        chk("op1_lat1", 32'(res_valid), 32'd0);
        tick();
        chk("op1_lat2", 32'(res_valid), 32'd1);
        chk("op1_data", 32'(res_data), 32'd37);
        pert = 6'h3F;
        tick();
        tick();
        chk("op1_hold_valid", 32'(res_valid), 32'd1);
        chk("op1_hold_data", 32'(res_data), 32'd37);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        pert = '0;
        chk("op1_drain", 32'(res_valid), 32'd0);
        chk("op1_idle", 32'(busy), 32'd0);

        op_data = 4'b0101;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        cfg_en = 1'b1;
        cfg_bit = 1'b1;
        cfg_commit = 1'b1;
        tick();
        cfg_en = 1'b0;
        cfg_bit = 1'b0;
        cfg_commit = 1'b0;
        chk("eval_cfg_err", 32'(cfg_err), 32'd1);
        chk("eval_comb_in", 32'(comb_in), 32'({W1, 4'b0101}));
        chk("eval_cfg_valid", 32'(cfg_valid), 32'd1);
        tick();
        chk("op2_valid", 32'(res_valid), 32'd1);
        chk("op2_data", 32'(res_data), 32'd35);

        rst = 1'b1;
        #1;
        chk("arst_res_valid", 32'(res_valid), 32'd0);
        chk("arst_res_data", 32'(res_data), 32'd0);
        chk("arst_cfg_err", 32'(cfg_err), 32'd0);
        chk("arst_cfg_valid", 32'(cfg_valid), 32'd0);
        chk("arst_comb_in", 32'(comb_in), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        shift_word(W1, 0, 20, 1'b0, 1'b0);
        commit();
        chk("short_err", 32'(cfg_err), 32'd1);
        chk("short_valid", 32'(cfg_valid), 32'd0);
        op_valid = 1'b1;
        #1;
        chk("short_ready", 32'(op_ready), 32'd0);
        tick();
        op_valid = 1'b0;
        chk("short_busy", 32'(busy), 32'd0);

        shift_word(W2, 2, SH_W, 1'b1, 1'b0);
        chk("sat_valid", 32'(cfg_valid), 32'd1);
        chk("sat_comb_in", 32'(comb_in), 32'({W2, 4'b0000}));
        chk("sat_err_sticky", 32'(cfg_err), 32'd1);
        op_data = 4'b1100;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        chk("op3_valid", 32'(res_valid), 32'd1);
        chk("op3_data", 32'(res_data), 32'd57);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("op3_drain", 32'(res_valid), 32'd0);

`ifdef UCOMB_CFG_PARITY_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        shift_word(W1, 0, SH_W, 1'b0, 1'b1);
        commit();
        chk("par_bad_err", 32'(cfg_err), 32'd1);
        chk("par_bad_valid", 32'(cfg_valid), 32'd0);
        shift_word(W1, 0, SH_W, 1'b0, 1'b0);
        commit();
        chk("par_ok_valid", 32'(cfg_valid), 32'd1);
        chk("par_ok_comb_in", 32'(comb_in), 32'({W1, 4'b0000}));
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
